// File: rtl/top_pkg.sv
// Shared types and defaults for the CSI-2 RX lane de-skew / word-align stage.
// Provides the lane-valid vector type, the align controller state type,
// the error counter type and default timer limits.
package top_pkg;

    localparam int unsigned NUM_LANE = 2;
    typedef logic [NUM_LANE-1:0] lane_vld_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        HUNT  = 2'd2,
        LOCK  = 2'd3
    } align_state_t;

    localparam int unsigned ERR_CNT_W = 8;
    typedef logic [ERR_CNT_W-1:0] err_cnt_t;

    localparam int unsigned HUNT_TIMEOUT_DEF = 4095;
    localparam int unsigned MAX_PKT_CYC_DEF  = 65535;
    localparam int unsigned FLUSH_CYC_DEF    = 4;
    localparam int unsigned SKEW_MAX_DEF     = 2;

endpackage

// File: rtl/csi_rx_sat_cnt.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   byte_clock  clock
//   reset       asynchronous active-high reset (count -> 0)
//   clear       synchronous clear
//   inc         increment request (ignored once the count is all-ones)
//   count       current count
module csi_rx_sat_cnt #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             byte_clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Hold at all-ones instead of wrapping.
    always_ff @(posedge byte_clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/csi_rx_align_ctrl.sv
// Sequencing controller for the CSI-2 RX word aligner (lane de-skew stage).
// Walks IDLE -> FLUSH -> HUNT -> LOCK, recovers from lane skew and from
// packets that never terminate by forcing a flush, and keeps saturating
// error counters for the status block.
// Ports:
//   byte_clock       clock
//   reset            asynchronous active-high reset
//   cfg_en           receiver enable
//   lane_vld_in      per-lane valid from the byte aligners
//   align_vld        word aligner valid_out
//   pkt_done_in      packet-done from the packet handler
//   align_en         word aligner enable
//   align_wait_sync  word aligner wait_for_sync
//   align_pkt_done   word aligner packet_done (combinational)
//   locked           high while in LOCK
//   hunt_timeout     one-cycle pulse after HUNT_TIMEOUT cycles without lock
//   err_skew_cnt     saturating skew fault count
//   err_pkt_to_cnt   saturating packet timeout count
module csi_rx_align_ctrl
    import top_pkg::*;
#(
    parameter int unsigned HUNT_TIMEOUT = HUNT_TIMEOUT_DEF,
    parameter int unsigned MAX_PKT_CYC  = MAX_PKT_CYC_DEF,
    parameter int unsigned FLUSH_CYC    = FLUSH_CYC_DEF,
    parameter int unsigned SKEW_MAX     = SKEW_MAX_DEF
) (
    input  logic                 byte_clock,
    input  logic                 reset,
    input  logic                 cfg_en,
    input  logic [NUM_LANE-1:0]  lane_vld_in,
    input  logic                 align_vld,
    input  logic                 pkt_done_in,
    output logic                 align_en,
    output logic                 align_wait_sync,
    output logic                 align_pkt_done,
    output logic                 locked,
    output logic                 hunt_timeout,
    output logic [ERR_CNT_W-1:0] err_skew_cnt,
    output logic [ERR_CNT_W-1:0] err_pkt_to_cnt
);

    localparam int unsigned HUNT_CNT_W  = 16;
    localparam int unsigned PKT_CNT_W   = 17;
    localparam int unsigned FLUSH_CNT_W = 4;
    localparam int unsigned SKEW_W      = $clog2(SKEW_MAX + 2);

    align_state_t          state, state_nxt;
    logic [HUNT_CNT_W-1:0]  hunt_cnt, hunt_cnt_nxt;
    logic [PKT_CNT_W-1:0]   pkt_cnt, pkt_cnt_nxt;
    logic [FLUSH_CNT_W-1:0] flush_cnt, flush_cnt_nxt;
    logic [SKEW_W-1:0]      skew_run, skew_run_nxt, skew_run_p1_c;
    logic                   partial_c;
    logic                   hunt_to_nxt;
    logic                   skew_inc_c;
    logic                   pkt_to_inc_c;

    // State, timers and Moore outputs; outputs are decoded from the next state
    // so they line up with the registered state.
    always_ff @(posedge byte_clock or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            hunt_cnt        <= '0;
            pkt_cnt         <= '0;
            flush_cnt       <= '0;
            skew_run        <= '0;
            hunt_timeout    <= 1'b0;
            align_en        <= 1'b0;
            align_wait_sync <= 1'b0;
            locked          <= 1'b0;
        end else begin
            state           <= state_nxt;
            hunt_cnt        <= hunt_cnt_nxt;
            pkt_cnt         <= pkt_cnt_nxt;
            flush_cnt       <= flush_cnt_nxt;
            skew_run        <= skew_run_nxt;
            hunt_timeout    <= hunt_to_nxt;
            align_en        <= (state_nxt != IDLE);
            align_wait_sync <= (state_nxt == HUNT);
            locked          <= (state_nxt == LOCK);
        end
    end

    // Some but not all lanes valid: lanes are skewed against each other.
    assign partial_c     = (|lane_vld_in) & ~(&lane_vld_in);
    assign skew_run_p1_c = partial_c ? (skew_run + SKEW_W'(1)) : '0;

    // Next-state and timer update.
    always_comb begin
        state_nxt     = state;
        hunt_cnt_nxt  = hunt_cnt;
        pkt_cnt_nxt   = pkt_cnt;
        flush_cnt_nxt = flush_cnt;
        skew_run_nxt  = skew_run;
        hunt_to_nxt   = 1'b0;
        skew_inc_c    = 1'b0;
        pkt_to_inc_c  = 1'b0;

        if (!cfg_en) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: state_nxt = FLUSH;
                FLUSH: begin
                    if (flush_cnt == FLUSH_CNT_W'(FLUSH_CYC - 1)) begin
                        state_nxt = HUNT;
                    end else begin
                        flush_cnt_nxt = flush_cnt + FLUSH_CNT_W'(1);
                    end
                end
                HUNT: begin
                    skew_run_nxt = skew_run_p1_c;
                    if (align_vld) begin
                        state_nxt = LOCK;
                    end else if (skew_run_p1_c == SKEW_W'(SKEW_MAX + 1)) begin
                        skew_inc_c = 1'b1;
                        state_nxt  = FLUSH;
                    end else if (hunt_cnt == HUNT_CNT_W'(HUNT_TIMEOUT - 1)) begin
                        hunt_to_nxt  = 1'b1;
                        hunt_cnt_nxt = '0;
                    end else begin
                        hunt_cnt_nxt = hunt_cnt + HUNT_CNT_W'(1);
                    end
                end
                LOCK: begin
                    if (pkt_done_in) begin
                        state_nxt = HUNT;
                    end else if (pkt_cnt == PKT_CNT_W'(MAX_PKT_CYC - 1)) begin
                        pkt_to_inc_c = 1'b1;
                        state_nxt    = FLUSH;
                    end else if (!align_vld) begin
                        state_nxt = FLUSH;
                    end else begin
                        pkt_cnt_nxt = pkt_cnt + PKT_CNT_W'(1);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        // Every state entry starts all timers from zero.
        if (state_nxt != state) begin
            hunt_cnt_nxt  = '0;
            pkt_cnt_nxt   = '0;
            flush_cnt_nxt = '0;
            skew_run_nxt  = '0;
        end
    end

    // Packet-done passes straight through so the aligner sees it with no delay.
    assign align_pkt_done = (state == IDLE) || (state == FLUSH) || pkt_done_in;

    csi_rx_sat_cnt #(.WIDTH(ERR_CNT_W)) u_skew_cnt (
        .byte_clock (byte_clock),
        .reset      (reset),
        .clear      (1'b0),
        .inc        (skew_inc_c),
        .count      (err_skew_cnt)
    );

    csi_rx_sat_cnt #(.WIDTH(ERR_CNT_W)) u_pkt_to_cnt (
        .byte_clock (byte_clock),
        .reset      (reset),
        .clear      (1'b0),
        .inc        (pkt_to_inc_c),
        .count      (err_pkt_to_cnt)
    );

endmodule
